// File: rtl/ram64_pkg.sv
// Shared widths, select fields and load-routing helper for the ram64 memory slice.
package ram64_pkg;
    localparam int WIDTH    = 16;
    localparam int ADDR_W   = 6;
    localparam int BANK_MSB = 5;
    localparam int BANK_LSB = 3;
    localparam int WORD_MSB = 2;
    localparam int WORD_LSB = 0;

    typedef logic [WIDTH-1:0] word_t;

    // DMux8Way: route a single load onto one of eight outputs.
    function automatic logic [7:0] dmux8way(input logic i_load, input logic [2:0] i_sel);
        logic [7:0] v_out;
        v_out        = 8'h00;
        v_out[i_sel] = i_load;
        return v_out;
    endfunction
endpackage

// File: rtl/ram64_ram8.sv
// register16 storage cell and the 8-word ram8 bank built from it.
import ram64_pkg::*;

module register16 (
    input  logic  clk,
    input  logic  reset,
    input  word_t in,
    input  logic  load,
    output word_t out
);
    word_t r_q;
    word_t w_d;

    // Mux16 hold/load select
    assign w_d = load ? in : r_q;

    always_ff @(posedge clk) begin
        if (reset) r_q <= '0;
        else       r_q <= w_d;
    end

    assign out = r_q;
endmodule

module ram8 (
    input  logic       clk,
    input  logic       reset,
    input  word_t      in,
    input  logic       load,
    input  logic [2:0] address,
    output word_t      out
);
    logic [7:0] w_word_load;
    word_t      w_word_out [8];

    assign w_word_load = dmux8way(load, address);

    for (genvar g = 0; g < 8; g++) begin : g_word
        register16 u_reg (
            .clk   (clk),
            .reset (reset),
            .in    (in),
            .load  (w_word_load[g]),
            .out   (w_word_out[g])
        );
    end

    assign out = w_word_out[address];

    a_word_load_onehot0: assert property (@(posedge clk) $onehot0(w_word_load));
endmodule

// File: rtl/ram64.sv
// 64 x 16 Hack-style RAM: eight ram8 banks, synchronous write, combinational read.
import ram64_pkg::*;

module ram64 (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out
);
    logic [7:0] w_bank_load;
    logic [2:0] w_bank_sel;
    logic [2:0] w_word_sel;
    word_t      w_bank_out [8];

    assign w_bank_sel  = address[BANK_MSB:BANK_LSB];
    assign w_word_sel  = address[WORD_MSB:WORD_LSB];
    assign w_bank_load = dmux8way(load, w_bank_sel);

    for (genvar g = 0; g < 8; g++) begin : g_bank
        ram8 u_ram8 (
            .clk     (clk),
            .reset   (reset),
            .in      (in),
            .load    (w_bank_load[g]),
            .address (w_word_sel),
            .out     (w_bank_out[g])
        );
    end

    // Mux8Way16 across banks
    assign out = w_bank_out[w_bank_sel];

    a_bank_load_onehot0: assert property (@(posedge clk) $onehot0(w_bank_load));
endmodule

// File: tb/tb_ram64.sv
// Directed self-checking bench for ram64 against a 64-entry expected-contents array.
module tb_ram64;
    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic [5:0]  address;
    logic [15:0] out;

    logic [15:0] exp_mem [64];
    int          errors;
    int          checks;

    ram64 dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .load    (load),
        .address (address),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [5:0] a, input logic [15:0] d);
        address = a;
        in      = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load  = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            exp_mem[i] = 16'h0000;
            address = 6'(i);
            #1;
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_read addr=%0h got=%h want=0000", i, out);
            end
        end
    endtask

    task automatic test_single_write();
        logic [5:0] nb [4];
        nb[0] = 6'h29; nb[1] = 6'h2B; nb[2] = 6'h22; nb[3] = 6'h32;
        write_word(6'h2A, 16'hBEEF);
        address = 6'h2A;
        #1;
        checks++;
        if (out !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_write addr=2a got=%h want=beef", out);
        end
        for (int k = 0; k < 4; k++) begin
            address = nb[k];
            #1;
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("FAIL single_write_neighbor addr=%h got=%h want=0000", nb[k], out);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 64; i++) write_word(6'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 64; i++) begin
            address = 6'(i);
            #1;
            checks++;
            if (out !== 16'h1000 + 16'(i)) begin
                errors++;
                $display("FAIL fill_readback addr=%0h got=%h want=%h", i, out, 16'h1000 + 16'(i));
            end
        end
    endtask

    task automatic test_read_during_write();
        write_word(6'h07, 16'h1234);
        address = 6'h07;
        in      = 16'hABCD;
        load    = 1'b1;
        #1;
        checks++;
        if (out !== 16'h1234) begin
            errors++;
            $display("FAIL rdw_before_edge got=%h want=1234", out);
        end
        tick();
        load = 1'b0;
        exp_mem[7] = 16'hABCD;
        checks++;
        if (out !== 16'hABCD) begin
            errors++;
            $display("FAIL rdw_after_edge got=%h want=abcd", out);
        end
    endtask

    task automatic test_load_gating();
        load = 1'b0;
        in   = 16'h5555;
        for (int i = 0; i < 64; i++) begin
            address = 6'(i);
            tick();
            checks++;
            if (out !== exp_mem[i]) begin
                errors++;
                $display("FAIL load_gating addr=%0h got=%h want=%h", i, out, exp_mem[i]);
            end
        end
    endtask

    task automatic test_reset_beats_load();
        reset   = 1'b1;
        load    = 1'b1;
        address = 6'h3F;
        in      = 16'hFFFF;
        tick();
        reset = 1'b0;
        load  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            exp_mem[i] = 16'h0000;
            address = 6'(i);
            #1;
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_beats_load addr=%0h got=%h want=0000", i, out);
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset   = 1'b0;
        load    = 1'b0;
        in      = 16'h0000;
        address = 6'h00;
        #2;
        test_reset();
        test_single_write();
        test_fill();
        test_read_during_write();
        test_load_gating();
        test_reset_beats_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
